// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming 2x2 stride-2 max pool over half floats with a one-row line buffer of pair maxima.
// Define MAXPOOL_RELU_EN to fuse a ReLU onto each pooled result.
module max_pool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IH = 28,
  parameter int IW = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  frame_done
);
  localparam int OH = IH / 2;
  localparam int OW = IW / 2;
  localparam int RW = $clog2(IH + 1);
  localparam int CW = $clog2(IW + 1);
  localparam int IDX = OW > 1 ? $clog2(OW) : 1;
  typedef enum logic [1:0] {ROW_EVEN, ROW_ODD, ROW_DROP} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [IDX-1:0] idx;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, out_q, out_d, pair, win, res;
  logic [DATA_WIDTH-1:0] lb_q [OW];
  logic vld_q, vld_d, last_q, last_d, done_q, done_d;
  logic acc, last_col, eof, produce, lb_we;

  function automatic logic [DATA_WIDTH-1:0] key(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? ~x : x | {1'b1, {(DATA_WIDTH-1){1'b0}}};
  endfunction

  // a is the earlier-arriving operand and is kept on equal keys
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    return key(b) > key(a) ? b : a;
  endfunction

  assign in_ready = !vld_q || out_ready;

  always_comb begin
    acc = in_valid && in_ready;
    last_col = col_q == CW'(IW - 1);
    idx = IDX'(col_q >> 1);
    pair = fmax(hold_q, in_data);
    win = fmax(lb_q[idx], pair);
`ifdef MAXPOOL_RELU_EN
    res = win[DATA_WIDTH-1] ? '0 : win;
`else
    res = win;
`endif
    eof = state_q == ROW_DROP || (state_q == ROW_ODD && row_q == RW'(IH - 1));
    produce = acc && state_q == ROW_ODD && col_q[0];
    lb_we = acc && state_q == ROW_EVEN && col_q[0];
    hold_d = acc && !col_q[0] ? in_data : hold_q;
    col_d = acc ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d = acc && last_col ? (eof ? '0 : row_q + 1'b1) : row_q;
    state_d = state_q;
    if (acc && last_col)
      state_d = eof ? ROW_EVEN : state_q == ROW_EVEN ? ROW_ODD : row_q == RW'(IH - 2) ? ROW_DROP : ROW_EVEN;
    vld_d = produce || (vld_q && !out_ready);
    out_d = produce ? res : out_q;
    last_d = produce ? (row_q == RW'(2 * OH - 1) && col_q == CW'(2 * OW - 1)) : vld_q && out_ready ? 1'b0 : last_q;
    done_d = vld_q && out_ready && last_q;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ROW_EVEN;
      row_q <= '0;
      col_q <= '0;
      hold_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < OW; i++) lb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      hold_q <= hold_d;
      out_q <= out_d;
      vld_q <= vld_d;
      last_q <= last_d;
      done_q <= done_d;
      if (lb_we) lb_q[idx] <= pair;
    end

  assign out_data = out_q;
  assign out_valid = vld_q;
  assign out_last = last_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_max_pool_stream.sv
// tb_max_pool_stream: scoreboard bench over 4x4, 5x5 and 28x28 instances of max_pool_stream.
module tb_max_pool_stream;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0][15:0] in_data, out_data;
  logic [2:0] in_valid, in_ready, out_valid, out_ready, out_last, frame_done;
  logic [16:0] q [3][$];
  logic [2:0] pend;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  max_pool_stream #(.DATA_WIDTH(16), .IH(4), .IW(4)) u4 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_last(out_last[0]),
    .frame_done(frame_done[0]));
  max_pool_stream #(.DATA_WIDTH(16), .IH(5), .IW(5)) u5 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_last(out_last[1]),
    .frame_done(frame_done[1]));
  max_pool_stream #(.DATA_WIDTH(16), .IH(28), .IW(28)) u28 (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_last(out_last[2]),
    .frame_done(frame_done[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] i2h(input int v);
    int m, e;
    logic [15:0] h;
    m = v < 0 ? -v : v;
    if (m == 0) return 16'h0000;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    h = {1'b0, 5'(e + 15), 10'((m << (10 - e)) & 'h3FF)};
    return v < 0 ? (h | 16'h8000) : h;
  endfunction

  function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[15] ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  function automatic int pv(input int seed, input int r, input int c);
    return ((r * 7 + c * 13 + seed * 29) % 97) - 48;
  endfunction

  function automatic int max4(input int seed, input int r, input int c);
    int m;
    m = pv(seed, r, c);
    if (pv(seed, r, c + 1) > m) m = pv(seed, r, c + 1);
    if (pv(seed, r + 1, c) > m) m = pv(seed, r + 1, c);
    if (pv(seed, r + 1, c + 1) > m) m = pv(seed, r + 1, c + 1);
    return m;
  endfunction

  // caller is #1 after a posedge; returns #1 after the accepting posedge
  task automatic send(input int d, input logic [15:0] v);
    int n = 0;
    in_data[d] = v;
    in_valid[d] = 1'b1;
    @(negedge clk);
    while (!in_ready[d] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send%0d: in_ready stuck at 0, expected 1", d);
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic frame28(input int seed, input int npix);
    for (int k = 0; k < npix; k++) begin
      int r, c;
      r = k / 28;
      c = k % 28;
      if (r[0] && c[0]) q[2].push_back({r == 27 && c == 27, relu(i2h(max4(seed, r - 1, c - 1)))});
      send(2, i2h(pv(seed, r, c)));
    end
  endtask

  initial begin
    logic [16:0] e;
    pend = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (frame_done[d] || pend[d]) chk($sformatf("frame_done%0d", d), frame_done[d], pend[d]);
        pend[d] = 1'b0;
        if (out_valid[d] && out_ready[d]) begin
          if (q[d].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra%0d: got unexpected output %h, expected none", d, out_data[d]);
          end else begin
            e = q[d].pop_front();
            chk($sformatf("data%0d", d), out_data[d], e[15:0]);
            chk($sformatf("last%0d", d), out_last[d], e[16]);
            pend[d] = e[16];
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] f2 [16] = '{16'hC000, 16'hB800, 16'h4000, 16'h4000, 16'hC200, 16'hBC00, 16'h4000, 16'h4000,
                             16'h0000, 16'h8000, 16'h3C00, 16'h4400, 16'h8000, 16'h0000, 16'hC400, 16'h4200};
    in_data = '0;
    in_valid = '0;
    out_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid%0d", d), out_valid[d], 0);
      chk($sformatf("rst_data%0d", d), out_data[d], 0);
      chk($sformatf("rst_last%0d", d), out_last[d], 0);
      chk($sformatf("rst_done%0d", d), frame_done[d], 0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("rst_in_ready%0d", d), in_ready[d], 1);
    // 4x4: ramp frame then directed sign/tie frame back to back
    q[0].push_back({1'b0, 16'h4600});
    q[0].push_back({1'b0, 16'h4800});
    q[0].push_back({1'b0, 16'h4B00});
    q[0].push_back({1'b1, 16'h4C00});
    q[0].push_back({1'b0, relu(16'hB800)});
    q[0].push_back({1'b0, 16'h4000});
    q[0].push_back({1'b0, 16'h0000});
    q[0].push_back({1'b1, 16'h4400});
    for (int k = 0; k < 16; k++) send(0, i2h(k + 1));
    for (int k = 0; k < 16; k++) send(0, f2[k]);
    // 5x5: row 4 and col 4 hold 100.0 and must be dropped
    q[1].push_back({1'b0, 16'h4700});
    q[1].push_back({1'b0, 16'h4880});
    q[1].push_back({1'b0, 16'h4C40});
    q[1].push_back({1'b1, 16'h4CC0});
    for (int k = 0; k < 25; k++) send(1, (k / 5 == 4 || k % 5 == 4) ? i2h(100) : i2h(k + 1));
    repeat (5) @(posedge clk);
    #1;
    chk("drain4", q[0].size(), 0);
    chk("drain5", q[1].size(), 0);
    out_ready[2] = 1'b0;
    fork
      frame28(3, 784);
      begin
        repeat (40) @(negedge clk);
        chk("bp_valid", out_valid[2], 1);
        chk("bp_in_ready", in_ready[2], 0);
        chk("bp_data", out_data[2], relu(i2h(max4(3, 0, 0))));
        repeat (5) @(negedge clk);
        chk("bp_stable", out_data[2], relu(i2h(max4(3, 0, 0))));
        @(posedge clk);
        #1;
        out_ready[2] = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("bp_drain", q[2].size(), 0);
    frame28(5, 40);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", out_valid[2], 0);
    chk("midrst_drain", q[2].size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    frame28(7, 784);
    repeat (20) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("final_drain%0d", d), q[d].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
